// File: rtl/inmux_ctrl_q.sv
// inmux_ctrl_q: queues control-token selects, joins the selected data channel, registers the result.
// Define INMUX_CTRL_Q_SKID_EN to replace the single output register with a 2-entry skid buffer.
module inmux_ctrl_q #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CTRL_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_IN-1:0]                 t_k_req,
    output logic [NUM_IN-1:0]                 t_k_ack,
    input  logic [NUM_IN*DATA_W-1:0]          t_k_data,
    input  logic                              t_c_req,
    output logic                              t_c_ack,
    input  logic [SEL_W-1:0]                  t_c_sel,
    output logic                              i_inmux_req,
    input  logic                              i_inmux_ack,
    output logic [DATA_W-1:0]                 i_inmux_data,
    output logic [SEL_W-1:0]                  i_inmux_sel,
    output logic [7:0]                        err_cnt,
    output logic [$clog2(CTRL_DEPTH):0]       ctrl_level
);

    localparam int unsigned LVL_W = $clog2(CTRL_DEPTH) + 1;
    localparam int unsigned PTR_W = (CTRL_DEPTH > 1) ? $clog2(CTRL_DEPTH) : 1;

    logic [SEL_W-1:0]  r_fifo [CTRL_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [7:0]        r_err_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_head_v;
    logic [SEL_W-1:0]  w_head;
    logic              w_sel_ok;
    logic              w_can_load;
    logic              w_join;
    logic              w_bad;
    logic              w_load;
    logic              w_sel_req;
    logic [DATA_W-1:0] w_sel_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(CTRL_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign t_c_ack    = (r_level != LVL_W'(CTRL_DEPTH));
    assign w_push     = t_c_req && t_c_ack;
    assign w_head_v   = (r_level != '0);
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_sel_ok   = (int'(w_head) < int'(NUM_IN));
    assign w_join     = w_head_v && w_sel_ok && w_can_load;
    assign w_bad      = w_head_v && !w_sel_ok;
    assign w_load     = w_join && w_sel_req;
    assign w_pop      = w_load || w_bad;
    assign ctrl_level = r_level;
    assign err_cnt    = r_err_cnt;

    // NOTE: every signal driven in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        t_k_ack    = '0;
        w_sel_req  = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (int'(w_head) == i) begin
                t_k_ack[i] = w_join;
                w_sel_req  = t_k_req[i];
                w_sel_data = t_k_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: queue storage carries no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= t_c_sel;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef INMUX_CTRL_Q_SKID_EN
    logic [1:0]        r_ocnt;
    logic [DATA_W-1:0] r_d0;
    logic [DATA_W-1:0] r_d1;
    logic [SEL_W-1:0]  r_s0;
    logic [SEL_W-1:0]  r_s1;
    logic              w_drain;
    logic [1:0]        w_cnt_after;

    // Readiness comes only from stored occupancy, cutting the ack-to-ack combinational path.
    assign w_can_load  = (r_ocnt != 2'd2);
    assign w_drain     = (r_ocnt != 2'd0) && i_inmux_ack;
    assign w_cnt_after = r_ocnt - {1'b0, w_drain};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ocnt <= '0;
            r_d0   <= '0;
            r_d1   <= '0;
            r_s0   <= '0;
            r_s1   <= '0;
        end else begin
            if (w_drain && (r_ocnt == 2'd2)) begin
                r_d0 <= r_d1;
                r_s0 <= r_s1;
            end
            if (w_load) begin
                if (w_cnt_after == 2'd0) begin
                    r_d0 <= w_sel_data;
                    r_s0 <= w_head;
                end else begin
                    r_d1 <= w_sel_data;
                    r_s1 <= w_head;
                end
            end
            r_ocnt <= w_cnt_after + {1'b0, w_load};
        end
    end

    assign i_inmux_req  = (r_ocnt != 2'd0);
    assign i_inmux_data = r_d0;
    assign i_inmux_sel  = r_s0;
`else
    logic              r_out_req;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    assign w_can_load = !r_out_req || i_inmux_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_out_sel  <= '0;
        end else if (w_load) begin
            r_out_req  <= 1'b1;
            r_out_data <= w_sel_data;
            r_out_sel  <= w_head;
        end else if (i_inmux_ack) begin
            r_out_req  <= 1'b0;
        end
    end

    assign i_inmux_req  = r_out_req;
    assign i_inmux_data = r_out_data;
    assign i_inmux_sel  = r_out_sel;
`endif

endmodule

// File: tb/tb_inmux_ctrl_q.sv
// Directed bench for inmux_ctrl_q (NUM_IN=3 so select 3 is invalid); outputs scored against a queue.
module tb_inmux_ctrl_q;

    localparam int NI = 3;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int CD = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } tok_t;

    logic              clk;
    logic              reset_n;
    logic [NI-1:0]     t_k_req;
    logic [NI-1:0]     t_k_ack;
    logic [NI*DW-1:0]  t_k_data;
    logic              t_c_req;
    logic              t_c_ack;
    logic [SW-1:0]     t_c_sel;
    logic              i_inmux_req;
    logic              i_inmux_ack;
    logic [DW-1:0]     i_inmux_data;
    logic [SW-1:0]     i_inmux_sel;
    logic [7:0]        err_cnt;
    logic [1:0]        ctrl_level;

    logic [DW-1:0]     ch_data [NI];
    tok_t              sb [$];
    tok_t              m_exp;
    int                n_pass  = 0;
    int                n_fail  = 0;
    int                n_total = 0;
    int                n_out   = 0;
    int                out_mark;

    assign t_k_data = {ch_data[2], ch_data[1], ch_data[0]};

    inmux_ctrl_q #(.NUM_IN(NI), .DATA_W(DW), .SEL_W(SW), .CTRL_DEPTH(CD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .t_k_req      (t_k_req),
        .t_k_ack      (t_k_ack),
        .t_k_data     (t_k_data),
        .t_c_req      (t_c_req),
        .t_c_ack      (t_c_ack),
        .t_c_sel      (t_c_sel),
        .i_inmux_req  (i_inmux_req),
        .i_inmux_ack  (i_inmux_ack),
        .i_inmux_data (i_inmux_data),
        .i_inmux_sel  (i_inmux_sel),
        .err_cnt      (err_cnt),
        .ctrl_level   (ctrl_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input int s);
        tok_t t;
        t.data = ch_data[s];
        t.sel  = SW'(s);
        sb.push_back(t);
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted output token must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && i_inmux_req && i_inmux_ack) begin
            n_out++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                m_exp = sb.pop_front();
                check("out_data", 64'(i_inmux_data), 64'(m_exp.data));
                check("out_sel", 64'(i_inmux_sel), 64'(m_exp.sel));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        t_c_req     = 1'b1;
        t_c_sel     = '0;
        t_k_req     = 3'b111;
        i_inmux_ack = 1'b0;
        ch_data[0]  = '0;
        ch_data[1]  = '0;
        ch_data[2]  = '0;

        // reset held with requests active
        repeat (2) tick();
        smp();
        check("rst_req", 64'(i_inmux_req), 64'(0));
        check("rst_data", 64'(i_inmux_data), 64'(0));
        check("rst_sel", 64'(i_inmux_sel), 64'(0));
        check("rst_err", 64'(err_cnt), 64'(0));
        check("rst_level", 64'(ctrl_level), 64'(0));
        check("rst_kack", 64'(t_k_ack), 64'(0));
        tick();
        reset_n = 1'b1;
        t_c_req = 1'b0;
        t_k_req = '0;
        smp();
        check("rel_cack", 64'(t_c_ack), 64'(1));
        check("rel_err", 64'(err_cnt), 64'(0));
        tick();

        // ordered select 2 then 0
        ch_data[0]  = 32'h0000BEEF;
        ch_data[1]  = 32'h11110001;
        ch_data[2]  = 32'hAAAA0002;
        t_k_req     = 3'b111;
        i_inmux_ack = 1'b1;
        t_c_req     = 1'b1;
        t_c_sel     = 2'd2;
        exp_push(2);
        smp();
        check("ord_noack", 64'(t_k_ack), 64'(0));
        tick();
        t_c_sel = 2'd0;
        exp_push(0);
        smp();
        check("ord_ack_ch2", 64'(t_k_ack), 64'(3'b100));
        tick();
        t_c_req = 1'b0;
        smp();
        check("ord_ack_ch0", 64'(t_k_ack), 64'(3'b001));
        check("ord_req1", 64'(i_inmux_req), 64'(1));
        check("ord_data1", 64'(i_inmux_data), 64'(32'hAAAA0002));
        check("ord_sel1", 64'(i_inmux_sel), 64'(2));
        tick();
        smp();
        check("ord_data2", 64'(i_inmux_data), 64'(32'h0000BEEF));
        check("ord_sel2", 64'(i_inmux_sel), 64'(0));
        check("ord_idle_ack", 64'(t_k_ack), 64'(0));
        tick();
        smp();
        check("ord_drained", 64'(i_inmux_req), 64'(0));
        tick();

        // backpressure: consumer stalled for 6 cycles
        ch_data[0]  = 32'hD0D0_0000;
        ch_data[1]  = 32'hC0DE_0001;
        t_k_req     = 3'b011;
        i_inmux_ack = 1'b0;
        t_c_req     = 1'b1;
        t_c_sel     = 2'd1;
        exp_push(1);
        smp();
        check("bp_noack0", 64'(t_k_ack), 64'(0));
        tick();
        t_c_sel = 2'd0;
        exp_push(0);
        smp();
        check("bp_ack_ch1", 64'(t_k_ack), 64'(3'b010));
        tick();
        t_c_sel = 2'd1;
        exp_push(1);
        smp();
        check("bp_stage_full", 64'(t_k_ack), 64'(0));
        check("bp_req", 64'(i_inmux_req), 64'(1));
        tick();
        t_c_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("bp_hold_req", 64'(i_inmux_req), 64'(1));
            check("bp_hold_data", 64'(i_inmux_data), 64'(32'hC0DE_0001));
            check("bp_hold_sel", 64'(i_inmux_sel), 64'(1));
            check("bp_kack", 64'(t_k_ack), 64'(0));
            check("bp_level", 64'(ctrl_level), 64'(CD));
            check("bp_cack", 64'(t_c_ack), 64'(0));
            tick();
        end
        i_inmux_ack = 1'b1;
        smp();
        check("bp_rel_ack_ch0", 64'(t_k_ack), 64'(3'b001));
        tick();
        smp();
        check("bp_rel_ack_ch1", 64'(t_k_ack), 64'(3'b010));
        tick();
        smp();
        tick();
        smp();
        check("bp_drained", 64'(i_inmux_req), 64'(0));
        check("bp_level0", 64'(ctrl_level), 64'(0));
        tick();

        // invalid select 3
        t_k_req = 3'b111;
        t_c_req = 1'b1;
        t_c_sel = 2'd3;
        smp();
        tick();
        t_c_req = 1'b0;
        smp();
        check("inv_noack", 64'(t_k_ack), 64'(0));
        check("inv_err0", 64'(err_cnt), 64'(0));
        check("inv_level1", 64'(ctrl_level), 64'(1));
        tick();
        smp();
        check("inv_err1", 64'(err_cnt), 64'(1));
        check("inv_popped", 64'(ctrl_level), 64'(0));
        check("inv_noout", 64'(i_inmux_req), 64'(0));
        tick();
        t_c_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            smp();
            check("inv_stream_noack", 64'(t_k_ack), 64'(0));
            tick();
        end
        t_c_req = 1'b0;
        repeat (2) begin
            smp();
            tick();
        end
        smp();
        check("inv_err_sat", 64'(err_cnt), 64'(255));
        check("inv_level_end", 64'(ctrl_level), 64'(0));
        tick();

        // throughput: 64 tokens back to back
        ch_data[0] = 32'h1000_0000;
        ch_data[1] = 32'h2000_0001;
        ch_data[2] = 32'h3000_0002;
        out_mark   = n_out;
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin
                t_c_req = 1'b1;
                t_c_sel = SW'(i % 3);
                exp_push(i % 3);
            end else begin
                t_c_req = 1'b0;
            end
            smp();
            if (i >= 2) check("tp_consecutive", 64'(i_inmux_req), 64'(1));
            tick();
        end
        smp();
        check("tp_done", 64'(i_inmux_req), 64'(0));
        check("tp_count", 64'(n_out - out_mark), 64'(64));
        tick();

        // reset mid-stream with two queued selects and a held output
        i_inmux_ack = 1'b0;
        t_c_req     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_c_sel = SW'(i);
            exp_push(i);
            smp();
            tick();
        end
        t_c_req = 1'b0;
        smp();
        check("mr_level2", 64'(ctrl_level), 64'(2));
        check("mr_req1", 64'(i_inmux_req), 64'(1));
        reset_n = 1'b0;
        sb.delete();
        tick();
        smp();
        check("mr_level0", 64'(ctrl_level), 64'(0));
        check("mr_req0", 64'(i_inmux_req), 64'(0));
        check("mr_err0", 64'(err_cnt), 64'(0));
        tick();
        reset_n     = 1'b1;
        i_inmux_ack = 1'b1;
        t_k_req     = 3'b111;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("mr_no_kack", 64'(t_k_ack), 64'(0));
            check("mr_no_out", 64'(i_inmux_req), 64'(0));
            tick();
        end

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
